// File: rtl/cache_repl_alloc_pkg.sv
// Shared definitions for the replacement-policy allocation controller: FSM state
// encoding, geometry macros and a lowest-clear-bit priority encoder.

`ifndef CS_LINES
`define CS_LINES (CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS))
`endif
`ifndef CS_LINE_SEL_BITS
`define CS_LINE_SEL_BITS ((`CS_LINES > 1) ? $clog2(`CS_LINES) : 1)
`endif
`ifndef CS_WAY_SEL_WIDTH
`define CS_WAY_SEL_WIDTH ((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)
`endif

package cache_repl_alloc_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_RESP    = 2'd3
    } cache_repl_state_e;

    // Index of the lowest clear bit among the first n bits of v (0 if none clear).
    function automatic int first_zero(input logic [31:0] v, input int n);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (i < n && !v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_repl_alloc_victim_sel.sv
// Combinational victim selection: picks the way to fill and whether it needs a writeback.
// Build option CACHE_REPL_INVALID_FIRST_EN prefers the lowest-index invalid way.

module cache_repl_alloc_victim_sel
    import cache_repl_alloc_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WSW      = 2
) (
    input  logic [WSW-1:0]      repl_way,
    input  logic [NUM_WAYS-1:0] tag_valid,
    input  logic [NUM_WAYS-1:0] tag_dirty,
    output logic [WSW-1:0]      way,
    output logic                evict
);

    always_comb begin
        way = (NUM_WAYS > 1) ? repl_way : '0;
`ifdef CACHE_REPL_INVALID_FIRST_EN
        if (!(&tag_valid)) begin
            way = WSW'(first_zero(32'(tag_valid), NUM_WAYS));
        end
`endif
        // A chosen invalid way naturally yields evict=0 here.
        evict = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (way == WSW'(i)) evict = tag_valid[i] & tag_dirty[i];
        end
    end

endmodule

// File: rtl/cache_repl_alloc.sv
// Requester-side controller for the replacement-policy interface: init sweep after
// reset/flush, then one policy read per miss allocation. Option: CACHE_REPL_INVALID_FIRST_EN.
//
// Handshakes: a request transfers on a cycle where alloc_valid && alloc_ready; a response
// transfers where rsp_valid && rsp_ready. rsp_* stay stable while rsp_valid && !rsp_ready.

module cache_repl_alloc
    import cache_repl_alloc_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 64,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 4,
    parameter int LINES      = `CS_LINES,
    parameter int LSB        = `CS_LINE_SEL_BITS,
    parameter int WSW        = `CS_WAY_SEL_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_req,
    output logic                init_done,
    input  logic                alloc_valid,
    input  logic [LSB-1:0]      alloc_line,
    output logic                alloc_ready,
    input  logic [NUM_WAYS-1:0] tag_valid,
    input  logic [NUM_WAYS-1:0] tag_dirty,
    output logic                repl_init,
    output logic                repl_valid,
    output logic [LSB-1:0]      repl_line,
    input  logic [WSW-1:0]      repl_way,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LSB-1:0]      rsp_line,
    output logic [WSW-1:0]      rsp_way,
    output logic                rsp_evict
);

    localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES - 1);

    cache_repl_state_e state_q, state_d;
    logic [LSB-1:0] cnt_q, cnt_d;
    logic [LSB-1:0] line_q, line_d;
    logic           init_done_q, init_done_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [LSB-1:0] rsp_line_q, rsp_line_d;
    logic [WSW-1:0] rsp_way_q, rsp_way_d;
    logic           rsp_evict_q, rsp_evict_d;
    logic [WSW-1:0] sel_way;
    logic           sel_evict;

    cache_repl_alloc_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .WSW      (WSW)
    ) u_victim_sel (
        .repl_way  (repl_way),
        .tag_valid (tag_valid),
        .tag_dirty (tag_dirty),
        .way       (sel_way),
        .evict     (sel_evict)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            line_q      <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_line_q  <= '0;
            rsp_way_q   <= '0;
            rsp_evict_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_line_q  <= rsp_line_d;
            rsp_way_q   <= rsp_way_d;
            rsp_evict_q <= rsp_evict_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_line_d  = rsp_line_q;
        rsp_way_d   = rsp_way_q;
        rsp_evict_d = rsp_evict_q;
        alloc_ready = 1'b0;
        repl_valid  = 1'b0;
        repl_init   = 1'b0;

        case (state_q)
            ST_INIT: begin
                repl_init = 1'b1;
                if (cnt_q == LAST_LINE) begin
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                alloc_ready = init_done_q && !flush_req;
                if (flush_req) begin
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_INIT;
                end else if (alloc_valid && init_done_q) begin
                    repl_valid = 1'b1;
                    line_d     = alloc_line;
                    state_d    = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                rsp_valid_d = 1'b1;
                rsp_line_d  = line_q;
                rsp_way_d   = sel_way;
                rsp_evict_d = sel_evict;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Policy strobes stay quiet while reset is held, whatever the current state.
        if (reset) begin
            alloc_ready = 1'b0;
            repl_valid  = 1'b0;
            repl_init   = 1'b0;
        end
    end

    assign repl_line = (state_q == ST_INIT) ? cnt_q : alloc_line;
    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_line  = rsp_line_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_evict = rsp_evict_q;

endmodule

// File: tb/tb_cache_repl_alloc.sv
// Directed bench for cache_repl_alloc with default geometry (4 sets, 4 ways).

module tb_cache_repl_alloc;

    localparam int LSB = 2;
    localparam int WSW = 2;
    localparam int NW  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush_req;
    logic           init_done;
    logic           alloc_valid;
    logic [LSB-1:0] alloc_line;
    logic           alloc_ready;
    logic [NW-1:0]  tag_valid;
    logic [NW-1:0]  tag_dirty;
    logic           repl_init;
    logic           repl_valid;
    logic [LSB-1:0] repl_line;
    logic [WSW-1:0] repl_way;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [LSB-1:0] rsp_line;
    logic [WSW-1:0] rsp_way;
    logic           rsp_evict;

    int checks   = 0;
    int failures = 0;

    cache_repl_alloc dut (
        .clk         (clk),
        .reset       (reset),
        .flush_req   (flush_req),
        .init_done   (init_done),
        .alloc_valid (alloc_valid),
        .alloc_line  (alloc_line),
        .alloc_ready (alloc_ready),
        .tag_valid   (tag_valid),
        .tag_dirty   (tag_dirty),
        .repl_init   (repl_init),
        .repl_valid  (repl_valid),
        .repl_line   (repl_line),
        .repl_way    (repl_way),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_line    (rsp_line),
        .rsp_way     (rsp_way),
        .rsp_evict   (rsp_evict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [LSB-1:0] l,
                           input logic [WSW-1:0] w, input logic e);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_line"},  32'(rsp_line),  32'(l));
        chk({tag, "_way"},   32'(rsp_way),   32'(w));
        chk({tag, "_evict"}, 32'(rsp_evict), 32'(e));
    endtask

    initial begin
        reset = 1'b1; flush_req = 1'b0; alloc_valid = 1'b0; alloc_line = '0;
        tag_valid = '0; tag_dirty = '0; repl_way = '0; rsp_ready = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        settle();
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 0);
        chk("rst_repl_init", 32'(repl_init), 0);
        chk("rst_repl_valid", 32'(repl_valid), 0);
        chk_rsp("rst_rsp", 1'b0, 2'd0, 2'd0, 1'b0);

        // Init sweep: 4 cycles, alloc requests ignored meanwhile
        reset = 1'b0;
        alloc_valid = 1'b1;
        alloc_line = 2'd1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("sweep_repl_init", 32'(repl_init), 1);
            chk("sweep_repl_line", 32'(repl_line), 32'(i));
            chk("sweep_alloc_ready", 32'(alloc_ready), 0);
            chk("sweep_repl_valid", 32'(repl_valid), 0);
            chk("sweep_init_done", 32'(init_done), 0);
            tick();
        end
        alloc_valid = 1'b0;
        settle();
        chk("idle_init_done", 32'(init_done), 1);
        chk("idle_repl_init", 32'(repl_init), 0);
        chk("idle_alloc_ready", 32'(alloc_ready), 1);
        chk("idle_repl_valid_quiet", 32'(repl_valid), 0);

        // Basic alloc: line 2, policy way 3, way 3 valid+dirty
        alloc_valid = 1'b1; alloc_line = 2'd2;
        settle();
        chk("basic_accept", 32'(alloc_ready), 1);
        chk("basic_repl_valid", 32'(repl_valid), 1);
        chk("basic_repl_line", 32'(repl_line), 2);
        tick();
        alloc_valid = 1'b0; alloc_line = 2'd0;
        repl_way = 2'd3; tag_valid = 4'hF; tag_dirty = 4'h8;
        settle();
        chk("basic_t1_repl_valid", 32'(repl_valid), 0);
        chk("basic_t1_alloc_ready", 32'(alloc_ready), 0);
        chk("basic_t1_rsp_valid", 32'(rsp_valid), 0);
        tick();
        repl_way = 2'd0; tag_valid = '0; tag_dirty = '0;
        settle();
        chk_rsp("basic_rsp", 1'b1, 2'd2, 2'd3, 1'b1);
        chk("basic_t2_repl_valid", 32'(repl_valid), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        settle();
        chk("basic_rsp_done", 32'(rsp_valid), 0);

        // Backpressure: response held for 5 cycles, next request waits
        alloc_valid = 1'b1; alloc_line = 2'd1;
        tick();
        alloc_valid = 1'b0;
        repl_way = 2'd1; tag_valid = 4'hF; tag_dirty = 4'h0;
        tick();
        alloc_valid = 1'b1; alloc_line = 2'd3;
        for (int i = 0; i < 5; i++) begin
            repl_way = 2'(i); tag_valid = 4'(i * 3); tag_dirty = 4'hF;
            settle();
            chk_rsp("bp_hold", 1'b1, 2'd1, 2'd1, 1'b0);
            chk("bp_alloc_ready", 32'(alloc_ready), 0);
            chk("bp_repl_valid", 32'(repl_valid), 0);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp_hs_alloc_ready", 32'(alloc_ready), 0);
        chk("bp_hs_rsp_valid", 32'(rsp_valid), 1);
        tick();
        rsp_ready = 1'b0;
        settle();
        chk("bp_after_rsp_valid", 32'(rsp_valid), 0);
        chk("bp_second_accept", 32'(alloc_ready), 1);
        chk("bp_second_repl_valid", 32'(repl_valid), 1);
        chk("bp_second_repl_line", 32'(repl_line), 3);
        tick();
        alloc_valid = 1'b0;
        repl_way = 2'd2; tag_valid = 4'hF; tag_dirty = 4'b0100;
        tick();
        settle();
        chk_rsp("bp_second_rsp", 1'b1, 2'd3, 2'd2, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Flush beats a same-cycle alloc, sweep repeats, then alloc accepted
        flush_req = 1'b1; alloc_valid = 1'b1; alloc_line = 2'd0;
        settle();
        chk("flush_alloc_ready", 32'(alloc_ready), 0);
        chk("flush_repl_valid", 32'(repl_valid), 0);
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("fsweep_init_done", 32'(init_done), 0);
            chk("fsweep_repl_init", 32'(repl_init), 1);
            chk("fsweep_repl_line", 32'(repl_line), 32'(i));
            chk("fsweep_alloc_ready", 32'(alloc_ready), 0);
            chk("fsweep_repl_valid", 32'(repl_valid), 0);
            tick();
        end
        settle();
        chk("flush_done_init_done", 32'(init_done), 1);
        chk("flush_then_accept", 32'(alloc_ready), 1);
        chk("flush_then_repl_valid", 32'(repl_valid), 1);
        chk("flush_then_repl_line", 32'(repl_line), 0);
        tick();

        // Victim select with an invalid way present
        alloc_valid = 1'b0;
        repl_way = 2'd0; tag_valid = 4'b1011; tag_dirty = 4'b1111;
        tick();
        repl_way = 2'd3; tag_valid = 4'h0; tag_dirty = 4'h0;
        settle();
`ifdef CACHE_REPL_INVALID_FIRST_EN
        chk_rsp("invfirst_rsp", 1'b1, 2'd0, 2'd2, 1'b0);
`else
        chk_rsp("invfirst_rsp", 1'b1, 2'd0, 2'd0, 1'b1);
`endif

        // Reset while a response is pending: dropped, sweep restarts at line 0
        reset = 1'b1;
        tick();
        settle();
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_repl_init", 32'(repl_init), 0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("msweep_repl_init", 32'(repl_init), 1);
            chk("msweep_repl_line", 32'(repl_line), 32'(i));
            chk("msweep_rsp_valid", 32'(rsp_valid), 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("midrst_no_replay", 32'(rsp_valid), 0);
            chk("midrst_idle_init_done", 32'(init_done), 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
